// File: rtl/atm_session_ctrl.sv
// ATM card-session controller: account/PIN/menu/amount FSM, BCD keypad entry buffer, inactivity abort.
// Define ATM_PIN_LOCKOUT_EN to enter a sticky LOCKED state after MAX_PIN_FAILS wrong PINs.
module atm_session_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [1:0]  MAX_PIN_FAILS  = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        cancel,
  input  logic        sel_withdraw,
  input  logic        sel_transfer,
  input  logic [15:0] pin_ref,
  output logic [3:0]  state,
  output logic [15:0] entry_buf,
  output logic [2:0]  digit_cnt,
  output logic [15:0] acc_num,
  output logic [15:0] dest_acc,
  output logic [15:0] amount,
  output logic        is_transfer,
  output logic        txn_valid,
  output logic [1:0]  pin_fail_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_ACC    = 4'b0001,
    S_PIN    = 4'b0010,
    S_MENU   = 4'b0100,
    S_AMOUNT = 4'b1000,
    S_XFER   = 4'b1010,
    S_DONE   = 4'b1111,
    S_LOCKED = 4'b1110
  } state_e;

`ifdef ATM_PIN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] entry_buf_q, entry_buf_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [15:0] acc_num_q, acc_num_d;
  logic [15:0] dest_acc_q, dest_acc_d;
  logic [15:0] amount_q, amount_d;
  logic        is_transfer_q, is_transfer_d;
  logic        txn_valid_q, txn_valid_d;
  logic [1:0]  pin_fail_cnt_q, pin_fail_cnt_d;
  logic [31:0] tmr_q, tmr_d;

  logic       any_pulse, abort, clr_buf, take_digit, buf_full;
  logic [2:0] fails_nx;

  always_comb begin
    state_d        = state_q;
    entry_buf_d    = entry_buf_q;
    digit_cnt_d    = digit_cnt_q;
    acc_num_d      = acc_num_q;
    dest_acc_d     = dest_acc_q;
    amount_d       = amount_q;
    is_transfer_d  = is_transfer_q;
    txn_valid_d    = 1'b0;
    pin_fail_cnt_d = pin_fail_cnt_q;
    tmr_d          = tmr_q;
    abort          = 1'b0;
    clr_buf        = 1'b0;
    take_digit     = 1'b0;
    any_pulse      = start | digit_valid | enter | cancel | sel_withdraw | sel_transfer;
    buf_full       = (digit_cnt_q == 3'd4);
    fails_nx       = {1'b0, pin_fail_cnt_q} + 3'd1;

    // cancel > enter > digit_valid: a lower-priority pulse is dropped, not deferred
    case (state_q)
      S_IDLE: if (start) state_d = S_ACC;
      S_ACC, S_XFER: begin
        if (cancel) abort = 1'b1;
        else if (enter) begin
          if (buf_full) begin
            if (state_q == S_ACC) begin
              acc_num_d = entry_buf_q;
              state_d   = S_PIN;
            end else begin
              dest_acc_d = entry_buf_q;
              state_d    = S_AMOUNT;
            end
          end
        end else if (digit_valid) take_digit = 1'b1;
      end
      S_PIN: begin
        if (cancel) abort = 1'b1;
        else if (enter) begin
          if (buf_full) begin
            if (entry_buf_q == pin_ref) begin
              state_d        = S_MENU;
              pin_fail_cnt_d = 2'd0;
            end else begin
              clr_buf        = 1'b1;
              pin_fail_cnt_d = fails_nx[2] ? 2'd3 : fails_nx[1:0];
              if (LOCK_EN && (fails_nx >= {1'b0, MAX_PIN_FAILS})) state_d = S_LOCKED;
            end
          end
        end else if (digit_valid) take_digit = 1'b1;
      end
      S_MENU: begin
        if (cancel) abort = 1'b1;
        else if (sel_withdraw) begin
          state_d       = S_AMOUNT;
          is_transfer_d = 1'b0;
        end else if (sel_transfer) begin
          state_d       = S_XFER;
          is_transfer_d = 1'b1;
        end
      end
      S_AMOUNT: begin
        if (cancel) abort = 1'b1;
        else if (enter) begin
          if (digit_cnt_q != 3'd0) begin
            amount_d    = entry_buf_q;
            txn_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else if (digit_valid) take_digit = 1'b1;
      end
      S_DONE:   if (enter || cancel) state_d = S_IDLE;
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase

    // Timer only runs when no pulse arrived, so a timeout never collides with a latch.
    if (state_q != S_IDLE && state_q != S_LOCKED && !any_pulse &&
        tmr_q >= TIMEOUT_CYCLES - 32'd1)
      abort = 1'b1;

    if (abort) begin
      state_d        = S_IDLE;
      acc_num_d      = 16'h0;
      dest_acc_d     = 16'h0;
      amount_d       = 16'h0;
      is_transfer_d  = 1'b0;
      pin_fail_cnt_d = 2'd0;
      txn_valid_d    = 1'b0;
    end

    if (take_digit && !buf_full) begin
      entry_buf_d = {entry_buf_q[11:0], digit};
      digit_cnt_d = digit_cnt_q + 3'd1;
    end
    if (clr_buf || state_d != state_q) begin
      entry_buf_d = 16'h0;
      digit_cnt_d = 3'd0;
    end

    if (any_pulse || state_d != state_q || state_q == S_IDLE || state_q == S_LOCKED)
      tmr_d = 32'd0;
    else
      tmr_d = tmr_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      entry_buf_q    <= 16'h0;
      digit_cnt_q    <= 3'd0;
      acc_num_q      <= 16'h0;
      dest_acc_q     <= 16'h0;
      amount_q       <= 16'h0;
      is_transfer_q  <= 1'b0;
      txn_valid_q    <= 1'b0;
      pin_fail_cnt_q <= 2'd0;
      tmr_q          <= 32'd0;
    end else begin
      state_q        <= state_d;
      entry_buf_q    <= entry_buf_d;
      digit_cnt_q    <= digit_cnt_d;
      acc_num_q      <= acc_num_d;
      dest_acc_q     <= dest_acc_d;
      amount_q       <= amount_d;
      is_transfer_q  <= is_transfer_d;
      txn_valid_q    <= txn_valid_d;
      pin_fail_cnt_q <= pin_fail_cnt_d;
      tmr_q          <= tmr_d;
    end
  end

  assign state        = state_q;
  assign entry_buf    = entry_buf_q;
  assign digit_cnt    = digit_cnt_q;
  assign acc_num      = acc_num_q;
  assign dest_acc     = dest_acc_q;
  assign amount       = amount_q;
  assign is_transfer  = is_transfer_q;
  assign txn_valid    = txn_valid_q;
  assign pin_fail_cnt = pin_fail_cnt_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed session scenarios then random pulses vs a digit-queue model.
module tb_atm_session_ctrl;
  localparam int TO = 16;
`ifdef ATM_PIN_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam int MAXF = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 0, digit_valid = 0, enter = 0, cancel = 0, sel_withdraw = 0, sel_transfer = 0;
  logic [3:0]  digit = 0;
  logic [15:0] pin_ref = 0;
  logic [3:0]  state;
  logic [15:0] entry_buf, acc_num, dest_acc, amount;
  logic [2:0]  digit_cnt;
  logic        is_transfer, txn_valid;
  logic [1:0]  pin_fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  atm_session_ctrl #(.TIMEOUT_CYCLES(32'd16), .MAX_PIN_FAILS(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .cancel(cancel), .sel_withdraw(sel_withdraw), .sel_transfer(sel_transfer),
    .pin_ref(pin_ref), .state(state), .entry_buf(entry_buf), .digit_cnt(digit_cnt),
    .acc_num(acc_num), .dest_acc(dest_acc), .amount(amount), .is_transfer(is_transfer),
    .txn_valid(txn_valid), .pin_fail_cnt(pin_fail_cnt));

  always #5 clk = ~clk;

  // Reference model: session phase code, typed digits as a queue, idle-cycle count.
  int         m_st;
  logic [3:0] m_digs[$];
  logic [15:0] m_acc, m_dest, m_amt;
  int         m_xfer, m_txn, m_fails, m_idle;

  function automatic logic [15:0] m_pack();
    logic [15:0] v = 16'h0;
    foreach (m_digs[i]) v = (v << 4) | {12'h0, m_digs[i]};
    return v;
  endfunction

  function automatic void m_reset();
    m_st = 0; m_digs.delete(); m_acc = 0; m_dest = 0; m_amt = 0;
    m_xfer = 0; m_txn = 0; m_fails = 0; m_idle = 0;
  endfunction

  function automatic void m_push(logic [3:0] d);
    if (m_digs.size() < 4) m_digs.push_back(d);
  endfunction

  function automatic void m_step(bit st, bit dv, logic [3:0] dg, bit en, bit ca, bit sw, bit sx,
                                 logic [15:0] pref);
    int prev = m_st;
    bit ab = 0, clr = 0;
    bit pulse = st | dv | en | ca | sw | sx;
    m_txn = 0;
    case (prev)
      0: if (st) m_st = 1;
      1, 10: if (ca) ab = 1;
             else if (en) begin
               if (m_digs.size() == 4) begin
                 if (prev == 1) begin m_acc = m_pack(); m_st = 2; end
                 else begin m_dest = m_pack(); m_st = 8; end
               end
             end else if (dv) m_push(dg);
      2: if (ca) ab = 1;
         else if (en) begin
           if (m_digs.size() == 4) begin
             if (m_pack() == pref) begin m_st = 4; m_fails = 0; end
             else begin
               clr = 1;
               if (LOCK && m_fails + 1 >= MAXF) m_st = 14;
               m_fails = (m_fails + 1 > 3) ? 3 : m_fails + 1;
             end
           end
         end else if (dv) m_push(dg);
      4: if (ca) ab = 1;
         else if (sw) begin m_st = 8; m_xfer = 0; end
         else if (sx) begin m_st = 10; m_xfer = 1; end
      8: if (ca) ab = 1;
         else if (en) begin
           if (m_digs.size() > 0) begin m_amt = m_pack(); m_txn = 1; m_st = 15; end
         end else if (dv) m_push(dg);
      15: if (en || ca) m_st = 0;
      default: ;
    endcase
    if (prev != 0 && prev != 14 && !pulse && m_idle + 1 >= TO) ab = 1;
    if (ab) begin
      m_st = 0; m_acc = 0; m_dest = 0; m_amt = 0; m_xfer = 0; m_fails = 0; m_txn = 0;
    end
    if (clr || m_st != prev) m_digs.delete();
    if (pulse || m_st != prev || prev == 0 || prev == 14) m_idle = 0;
    else m_idle++;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("state", 32'(state), 32'(m_st));
    chk("entry_buf", 32'(entry_buf), 32'(m_pack()));
    chk("digit_cnt", 32'(digit_cnt), 32'(m_digs.size()));
    chk("acc_num", 32'(acc_num), 32'(m_acc));
    chk("dest_acc", 32'(dest_acc), 32'(m_dest));
    chk("amount", 32'(amount), 32'(m_amt));
    chk("is_transfer", 32'(is_transfer), 32'(m_xfer));
    chk("txn_valid", 32'(txn_valid), 32'(m_txn));
    chk("pin_fail_cnt", 32'(pin_fail_cnt), 32'(m_fails));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_outs"}, 32'({entry_buf, digit_cnt, acc_num, dest_acc, amount,
                              is_transfer, txn_valid, pin_fail_cnt} != 0), 0);
  endtask

  // Called at a negedge; applies one cycle of pulses and compares after the edge.
  task automatic cyc(bit st, bit dv, logic [3:0] dg, bit en, bit ca, bit sw, bit sx);
    start = st; digit_valid = dv; digit = dg; enter = en; cancel = ca;
    sel_withdraw = sw; sel_transfer = sx;
    m_step(st, dv, dg, en, ca, sw, sx, pin_ref);
    @(posedge clk);
    @(negedge clk);
    start = 0; digit_valid = 0; enter = 0; cancel = 0; sel_withdraw = 0; sel_transfer = 0;
    chk_model();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic key(logic [3:0] d);
    cyc(0, 1, d, 0, 0, 0, 0);
  endtask

  task automatic key4(logic [15:0] v);
    for (int i = 3; i >= 0; i--) key(v[i*4 +: 4]);
  endtask

  task automatic do_enter();  cyc(0, 0, 4'd0, 1, 0, 0, 0); endtask
  task automatic do_cancel(); cyc(0, 0, 4'd0, 0, 1, 0, 0); endtask
  task automatic do_start();  cyc(1, 0, 4'd0, 0, 0, 0, 0); endtask

  // Assert reset with pulses pending, check outputs clear before any edge, release at negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1; digit_valid = 1; digit = 4'd7; enter = 1;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_hold");
    start = 0; digit_valid = 0; enter = 0;
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    m_reset();
    #2;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // account entry
    do_start();
    chk("start_to_acc", 32'(state), 32'h1);
    key4(16'h1234);
    do_enter();
    chk("acc_to_pin", 32'(state), 32'h2);
    chk("acc_latched", 32'(acc_num), 32'h1234);

    // correct PIN, withdraw with a two-digit amount
    pin_ref = 16'h0567;
    key4(16'h0567);
    do_enter();
    chk("pin_ok", 32'(state), 32'h4);
    cyc(0, 0, 4'd0, 0, 0, 1, 1);
    chk("sel_both_withdraw", 32'(state), 32'h8);
    do_enter();
    chk("amount_empty_enter", 32'(state), 32'h8);
    key(4'd2); key(4'd0);
    do_enter();
    chk("txn_pulse", 32'(txn_valid), 32'h1);
    chk("amount_val", 32'(amount), 32'h0020);
    chk("done_state", 32'(state), 32'hF);
    idle(1);
    chk("txn_one_cycle", 32'(txn_valid), 32'h0);
    do_enter();
    chk("done_to_idle", 32'(state), 32'h0);

    // transfer: fifth digit ignored
    do_start(); key(4'd1); key(4'd2); key(4'd3);
    do_enter();
    chk("acc_short_enter", 32'(state), 32'h1);
    key(4'd4); do_enter();
    key4(16'h0567); do_enter();
    cyc(0, 0, 4'd0, 0, 0, 0, 1);
    chk("xfer_state", 32'(state), 32'hA);
    key4(16'h9876); key(4'd5);
    chk("fifth_ignored", 32'(entry_buf), 32'h9876);
    do_enter();
    chk("dest_latched", 32'(dest_acc), 32'h9876);
    chk("is_transfer", 32'(is_transfer), 32'h1);
    chk("xfer_to_amount", 32'(state), 32'h8);

    // enter+cancel together in AMOUNT: cancel wins
    key(4'd3);
    cyc(0, 1, 4'd4, 1, 1, 0, 0);
    chk("cancel_wins", 32'(state), 32'h0);
    chk("cancel_no_txn", 32'(txn_valid), 32'h0);
    chk("cancel_clears", 32'(acc_num), 32'h0);

    // three wrong PINs
    do_start(); key4(16'h1234); do_enter();
    for (int i = 0; i < 3; i++) begin key4(16'h9999); do_enter(); end
    if (LOCK) begin
      chk("locked", 32'(state), 32'hE);
      do_cancel(); do_start(); idle(TO + 2);
      chk("locked_sticky", 32'(state), 32'hE);
      do_reset();
    end else begin
      chk("retry_state", 32'(state), 32'h2);
      chk("retry_fails", 32'(pin_fail_cnt), 32'h3);
      key4(16'h9999); do_enter();
      chk("fails_saturate", 32'(pin_fail_cnt), 32'h3);
      do_cancel();
      chk("cancel_fails", 32'(pin_fail_cnt), 32'h0);
    end

    // inactivity timeout in PIN
    do_start(); key4(16'h1234); do_enter();
    idle(TO - 1);
    chk("pre_timeout", 32'(state), 32'h2);
    idle(1);
    chk("timeout_idle", 32'(state), 32'h0);
    chk("timeout_acc", 32'(acc_num), 32'h0);

    // reset mid-entry
    do_start(); key(4'd1); key(4'd2);
    do_reset();
    idle(1);
    chk("post_reset", 32'(state), 32'h0);

    // random pulses; PIN digits biased toward pin_ref so MENU is reached
    pin_ref = 16'h1111;
    for (int n = 0; n < 3000; n++) begin
      bit st, dv, en, ca, sw, sx;
      logic [3:0] dg;
      st = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 9) < 3);
      en = ($urandom_range(0, 99) < 12);
      ca = ($urandom_range(0, 99) < 3);
      sw = ($urandom_range(0, 99) < 8);
      sx = ($urandom_range(0, 99) < 8);
      dg = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom_range(0, 9));
      cyc(st, dv, dg, en, ca, sw, sx);
      if (n % 200 == 199) idle($urandom_range(TO - 2, TO + 1));
      if (n % 700 == 699) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
